cu_microsequencer: RTL and testbench
====================================

Name: cu_microsequencer

Overview:
- Next-address logic for the ARM simulator control unit.
- Holds the 7-bit microprogram state register that drives the microstore ROM index.
- Each cycle it consumes the sequencing fields of the current microword, the instruction-decoder entry address, memory handshake and condition flags, and selects the next state.
- Adds a bounded memory-wait watchdog that forces entry into a fault microroutine.

Parameters:
- SW, 7, state/microaddress width (ROM index width).
- FETCH_STATE, 7'd1, first state of the fetch routine; target of n=001.
- FAULT_STATE, 7'd127, target taken on memory-wait timeout.
- WAIT_MAX, 16, maximum consecutive MOC-wait cycles before timeout (1..255).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- mw_n  in  3  next-address mode field of current microword
- mw_s  in  2  condition-select field
- mw_inv  in  1  condition invert
- mw_cr  in  7  jump address field of current microword
- enc_addr  in  7  entry state from instruction decoder/encoder
- moc  in  1  memory operation complete
- cond_ok  in  1  ARM condition-code test result for current instruction
- ir_flag  in  1  instruction bit selected by datapath (e.g. I/L bit)
- state  out  7  current state; drives microstore ROM index
- mem_timeout  out  1  one-cycle pulse when watchdog fires
- wait_cnt  out  8  current consecutive-wait count (debug)

Behaviour:
- Reset (sync, clk edge with reset=1): state=0, wait_cnt=0, mem_timeout=0. Reset overrides every other input, including mid-wait.
- Condition: c = sel(mw_s: 00 moc, 01 cond_ok, 10 ir_flag, 11 1'b1) XOR mw_inv.
- Incrementer: inc = state+1, modulo 2^SW (127 wraps to 0).
- Next state by mw_n, registered on each rising edge (one-cycle latency from inputs to state):
  - 000 -> enc_addr
  - 001 -> FETCH_STATE
  - 010 -> mw_cr
  - 011 -> c ? mw_cr : inc
  - 100 (wait) -> c ? inc : state (hold)
  - 101 -> inc
  - 110 -> c ? enc_addr : inc
  - 111 -> 0 (reserved; treated as restart)
- Watchdog applies only when mw_n=100 and mw_s=00 (MOC wait):
  - Each cycle the hold is taken, wait_cnt increments (saturating at 255).
  - When wait_cnt==WAIT_MAX-1 and the hold would be taken again: next state=FAULT_STATE, mem_timeout=1 for that cycle (registered, visible the cycle after), wait_cnt cleared.
- wait_cnt clears on any cycle the hold is not taken, including when c becomes true on the same edge the limit is reached. Success beats timeout.
- Waits on other condition selects (mw_s!=00) hold indefinitely; no watchdog.
- mem_timeout is 0 on every cycle except the single registered pulse.
- X/unknown mw_n after reset is not tolerated. Default branch of the selector is state 0.

Decomposition:
- Shared package cu_pkg:
  - Mode constants N_ENC, N_FETCH, N_JUMP, N_CJUMP, N_WAIT, N_INC, N_CENC, N_RST.
  - Condition-select constants S_MOC, S_COND, S_IRF, S_TRUE.
  - SW width constant.
- One natural sub-module: cu_cond_mux (combinational 4:1 condition select + invert). Incrementer, next-state mux, state register and watchdog stay in the top.

Test Plan:
- Reset mid-wait: state=5, mw_n=100, reset=1 for 1 cycle -> state=0, wait_cnt=0, mem_timeout=0 next cycle.
- Increment/wrap: state=126, mw_n=101 for 2 cycles -> state 127 then 0.
- Decode dispatch: mw_n=000, enc_addr=7'd40 -> state=40 after one edge. Then mw_n=001 -> state=1.
- Conditional jump: mw_n=011, mw_s=01, mw_cr=7'd82, state=10:
  - cond_ok=1 -> state=82.
  - cond_ok=0 -> state=11.
  - Same with mw_inv=1 gives the inverse results.
- MOC wait then success: state=3, mw_n=100, mw_s=00, moc=0 for 4 cycles then 1 -> state held at 3, wait_cnt 1,2,3,4, then state=4 and wait_cnt=0.
- Timeout: WAIT_MAX=4, MOC wait with moc=0 held -> after 4 edges state=127, mem_timeout pulses high exactly 1 cycle, wait_cnt=0. Repeat with moc=1 on the limit edge -> state=inc, no pulse.

Source files
------------

// File: rtl/cu_pkg.sv
// ---------------------------------------------------------------------------
// cu_pkg
// Shared constants for the ARM-simulator control-unit microsequencer:
//   - SW         : microaddress / state width (microstore ROM index width)
//   - N_*        : next-address mode encodings carried in the microword n field
//   - S_*        : condition-select encodings carried in the microword s field
// ---------------------------------------------------------------------------
package cu_pkg;

    localparam int SW = 7;

    // Next-address modes (mw_n)
    localparam logic [2:0] N_ENC   = 3'b000;  // dispatch to decoder entry address
    localparam logic [2:0] N_FETCH = 3'b001;  // back to the fetch routine
    localparam logic [2:0] N_JUMP  = 3'b010;  // unconditional jump to mw_cr
    localparam logic [2:0] N_CJUMP = 3'b011;  // conditional jump to mw_cr
    localparam logic [2:0] N_WAIT  = 3'b100;  // hold until condition, then step
    localparam logic [2:0] N_INC   = 3'b101;  // sequential step
    localparam logic [2:0] N_CENC  = 3'b110;  // conditional dispatch
    localparam logic [2:0] N_RST   = 3'b111;  // reserved, restarts at state 0

    // Condition selects (mw_s)
    localparam logic [1:0] S_MOC   = 2'b00;
    localparam logic [1:0] S_COND  = 2'b01;
    localparam logic [1:0] S_IRF   = 2'b10;
    localparam logic [1:0] S_TRUE  = 2'b11;

endpackage

// File: rtl/cu_cond_mux.sv
// ---------------------------------------------------------------------------
// cu_cond_mux
// Combinational 4:1 condition select followed by an optional invert.
// Ports:
//   mw_s     in  2  condition select (moc / cond_ok / ir_flag / constant 1)
//   mw_inv   in  1  invert the selected condition
//   moc      in  1  memory operation complete
//   cond_ok  in  1  ARM condition-code test result
//   ir_flag  in  1  instruction bit picked by the datapath
//   c        out 1  resulting branch/wait condition
// ---------------------------------------------------------------------------
module cu_cond_mux (
    input  logic [1:0] mw_s,
    input  logic       mw_inv,
    input  logic       moc,
    input  logic       cond_ok,
    input  logic       ir_flag,
    output logic       c
);
    import cu_pkg::*;

    logic [3:0] sources;
    logic       selected;

    assign sources = {1'b1, ir_flag, cond_ok, moc};

    // One-hot decode of the select, OR-reduced against the sources.
    logic [3:0] pick;
    for (genvar gi = 0; gi < 4; gi++) begin : g_pick
        assign pick[gi] = (mw_s == 2'(gi)) & sources[gi];
    end

    always_comb begin
        selected = |pick;
        c        = selected ^ mw_inv;
    end

endmodule

// File: rtl/cu_microsequencer.sv
// ---------------------------------------------------------------------------
// cu_microsequencer
// Next-address logic for the control unit: holds the microprogram state
// register (microstore ROM index) and selects the next state from the
// sequencing fields of the current microword. A watchdog on MOC waits forces
// entry into the fault microroutine after WAIT_MAX consecutive hold cycles.
// Ports:
//   clk          in  1   rising-edge clock
//   reset        in  1   synchronous active-high reset
//   mw_n         in  3   next-address mode
//   mw_s         in  2   condition select
//   mw_inv       in  1   condition invert
//   mw_cr        in  SW  jump address field
//   enc_addr     in  SW  decoder entry address
//   moc          in  1   memory operation complete
//   cond_ok      in  1   condition-code test result
//   ir_flag      in  1   selected instruction bit
//   state        out SW  current state
//   mem_timeout  out 1   one-cycle pulse when the watchdog fires
//   wait_cnt     out 8   consecutive MOC-wait count
// ---------------------------------------------------------------------------
module cu_microsequencer #(
    parameter int             SW          = cu_pkg::SW,
    parameter logic [SW-1:0]  FETCH_STATE = 7'd1,
    parameter logic [SW-1:0]  FAULT_STATE = 7'd127,
    parameter int             WAIT_MAX    = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [2:0]    mw_n,
    input  logic [1:0]    mw_s,
    input  logic          mw_inv,
    input  logic [SW-1:0] mw_cr,
    input  logic [SW-1:0] enc_addr,
    input  logic          moc,
    input  logic          cond_ok,
    input  logic          ir_flag,
    output logic [SW-1:0] state,
    output logic          mem_timeout,
    output logic [7:0]    wait_cnt
);
    import cu_pkg::*;

    localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_MAX - 1);

    logic [SW-1:0] state_reg, state_next;
    logic [7:0]    wait_cnt_reg, wait_cnt_next;
    logic          timeout_reg, timeout_next;

    logic          c;
    logic [SW-1:0] inc;
    logic          moc_wait;
    logic          hold;

    cu_cond_mux u_cond (
        .mw_s    (mw_s),
        .mw_inv  (mw_inv),
        .moc     (moc),
        .cond_ok (cond_ok),
        .ir_flag (ir_flag),
        .c       (c)
    );

    always_comb begin
        inc           = state_reg + SW'(1);
        moc_wait      = (mw_n == N_WAIT) && (mw_s == S_MOC);
        hold          = (mw_n == N_WAIT) && !c;
        state_next    = '0;
        wait_cnt_next = '0;
        timeout_next  = 1'b0;

        unique case (mw_n)
            N_ENC:   state_next = enc_addr;
            N_FETCH: state_next = FETCH_STATE;
            N_JUMP:  state_next = mw_cr;
            N_CJUMP: state_next = c ? mw_cr : inc;
            N_WAIT:  state_next = c ? inc : state_reg;
            N_INC:   state_next = inc;
            N_CENC:  state_next = c ? enc_addr : inc;
            N_RST:   state_next = '0;
            default: state_next = '0;
        endcase

        // Only a hold that is actually taken counts toward the limit, so a
        // completing MOC on the limit cycle falls through to the normal step.
        if (moc_wait && hold) begin
            if (wait_cnt_reg == WAIT_LIMIT) begin
                state_next    = FAULT_STATE;
                timeout_next  = 1'b1;
                wait_cnt_next = '0;
            end else if (wait_cnt_reg != 8'hFF) begin
                wait_cnt_next = wait_cnt_reg + 8'd1;
            end else begin
                wait_cnt_next = wait_cnt_reg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= '0;
            wait_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            timeout_reg  <= timeout_next;
        end
    end

    assign state       = state_reg;
    assign wait_cnt    = wait_cnt_reg;
    assign mem_timeout = timeout_reg;

endmodule

// File: tb/tb_cu_microsequencer.sv
// ---------------------------------------------------------------------------
// tb_cu_microsequencer
// Two sequencer instances share one stimulus stream: dut_a with the default
// watchdog limit (16) and dut_b with a short limit (4). Directed scenarios
// check constant expectations; a randomized phase checks both instances
// against a behavioural model of the next-address rules.
// ---------------------------------------------------------------------------
module tb_cu_microsequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] mw_n;
    logic [1:0] mw_s;
    logic       mw_inv;
    logic [6:0] mw_cr;
    logic [6:0] enc_addr;
    logic       moc;
    logic       cond_ok;
    logic       ir_flag;

    logic [6:0] state_a, state_b;
    logic       to_a, to_b;
    logic [7:0] cnt_a, cnt_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cu_microsequencer #(.WAIT_MAX(16)) dut_a (
        .clk(clk), .reset(reset), .mw_n(mw_n), .mw_s(mw_s), .mw_inv(mw_inv),
        .mw_cr(mw_cr), .enc_addr(enc_addr), .moc(moc), .cond_ok(cond_ok),
        .ir_flag(ir_flag), .state(state_a), .mem_timeout(to_a), .wait_cnt(cnt_a)
    );

    cu_microsequencer #(.WAIT_MAX(4)) dut_b (
        .clk(clk), .reset(reset), .mw_n(mw_n), .mw_s(mw_s), .mw_inv(mw_inv),
        .mw_cr(mw_cr), .enc_addr(enc_addr), .moc(moc), .cond_ok(cond_ok),
        .ir_flag(ir_flag), .state(state_b), .mem_timeout(to_b), .wait_cnt(cnt_b)
    );

    // Advance one rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; mw_n = 3'b101; mw_s = 2'b11; mw_inv = 1'b0;
        mw_cr = 7'd0; enc_addr = 7'd0; moc = 1'b0; cond_ok = 1'b0; ir_flag = 1'b0;
    endtask

    // Put both instances in a known state via an unconditional jump.
    task automatic go_to(input logic [6:0] target);
        reset = 1'b0; mw_n = 3'b010; mw_cr = target;
        tick();
    endtask

    // Behavioural reference: one clock of the next-address rules.
    function automatic void ref_step(input int st, input int cnt, input int wmax,
                                     output int nst, output int ncnt, output int nto);
        int  selv;
        bit  cv;
        int  inc;
        bit  wait_moc;
        case (mw_s)
            2'd0: selv = moc;
            2'd1: selv = cond_ok;
            2'd2: selv = ir_flag;
            default: selv = 1;
        endcase
        cv = (selv != 0) ^ mw_inv;
        inc = (st + 1) % 128;
        wait_moc = (mw_n == 3'd4) && (mw_s == 2'd0);
        nto = 0;
        ncnt = 0;
        if (reset) begin
            nst = 0;
        end else if (wait_moc && !cv && cnt == wmax - 1) begin
            nst = 127;
            nto = 1;
        end else begin
            case (mw_n)
                3'd0: nst = enc_addr;
                3'd1: nst = 1;
                3'd2: nst = mw_cr;
                3'd3: nst = cv ? int'(mw_cr) : inc;
                3'd4: nst = cv ? inc : st;
                3'd5: nst = inc;
                3'd6: nst = cv ? int'(enc_addr) : inc;
                default: nst = 0;
            endcase
            if (wait_moc && !cv) ncnt = (cnt < 255) ? cnt + 1 : 255;
        end
    endfunction

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        n_cmp++;
        if (state_a !== 7'd0 || cnt_a !== 8'd0 || to_a !== 1'b0) begin
            n_err++;
            $display("FAIL reset_a: state=%0d cnt=%0d to=%0b, required 0/0/0", state_a, cnt_a, to_a);
        end
        n_cmp++;
        if (state_b !== 7'd0 || cnt_b !== 8'd0 || to_b !== 1'b0) begin
            n_err++;
            $display("FAIL reset_b: state=%0d cnt=%0d to=%0b, required 0/0/0", state_b, cnt_b, to_b);
        end
        $display("txn reset: state_a=%0d state_b=%0d", state_a, state_b);
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        idle_inputs();
        go_to(7'd5);
        mw_n = 3'b100; mw_s = 2'b00; moc = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (state_a !== 7'd5 || cnt_a !== 8'd2) begin
            n_err++;
            $display("FAIL mid_wait_pre: state=%0d cnt=%0d, required 5/2", state_a, cnt_a);
        end
        reset = 1'b1;
        tick();
        n_cmp++;
        if (state_a !== 7'd0 || cnt_a !== 8'd0 || to_a !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_wait: state=%0d cnt=%0d to=%0b, required 0/0/0", state_a, cnt_a, to_a);
        end
        $display("txn reset_mid_wait: state=%0d cnt=%0d", state_a, cnt_a);
        reset = 1'b0;
    endtask

    task automatic test_inc_wrap();
        idle_inputs();
        go_to(7'd126);
        mw_n = 3'b101;
        tick();
        n_cmp++;
        if (state_a !== 7'd127) begin
            n_err++;
            $display("FAIL inc_126: state=%0d, required 127", state_a);
        end
        tick();
        n_cmp++;
        if (state_a !== 7'd0) begin
            n_err++;
            $display("FAIL inc_wrap: state=%0d, required 0", state_a);
        end
        $display("txn inc_wrap: state=%0d", state_a);
    endtask

    task automatic test_dispatch();
        idle_inputs();
        mw_n = 3'b000; enc_addr = 7'd40;
        tick();
        n_cmp++;
        if (state_a !== 7'd40) begin
            n_err++;
            $display("FAIL dispatch_enc: state=%0d, required 40", state_a);
        end
        mw_n = 3'b001;
        tick();
        n_cmp++;
        if (state_a !== 7'd1) begin
            n_err++;
            $display("FAIL dispatch_fetch: state=%0d, required 1", state_a);
        end
        $display("txn dispatch: state=%0d", state_a);
    endtask

    task automatic test_cjump();
        logic [6:0] exp;
        for (int inv = 0; inv < 2; inv++) begin
            for (int co = 1; co >= 0; co--) begin
                idle_inputs();
                go_to(7'd10);
                mw_n = 3'b011; mw_s = 2'b01; mw_cr = 7'd82;
                mw_inv = inv[0]; cond_ok = co[0];
                tick();
                exp = ((co != 0) != (inv != 0)) ? 7'd82 : 7'd11;
                n_cmp++;
                if (state_a !== exp) begin
                    n_err++;
                    $display("FAIL cjump inv=%0d cond=%0d: state=%0d, required %0d", inv, co, state_a, exp);
                end
                $display("txn cjump inv=%0d cond=%0d: state=%0d", inv, co, state_a);
            end
        end
    endtask

    task automatic test_moc_wait();
        idle_inputs();
        go_to(7'd3);
        mw_n = 3'b100; mw_s = 2'b00; moc = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_cmp++;
            if (state_a !== 7'd3 || cnt_a !== 8'(i) || to_a !== 1'b0) begin
                n_err++;
                $display("FAIL moc_hold %0d: state=%0d cnt=%0d to=%0b, required 3/%0d/0", i, state_a, cnt_a, to_a, i);
            end
        end
        moc = 1'b1;
        tick();
        n_cmp++;
        if (state_a !== 7'd4 || cnt_a !== 8'd0) begin
            n_err++;
            $display("FAIL moc_done: state=%0d cnt=%0d, required 4/0", state_a, cnt_a);
        end
        $display("txn moc_wait: state=%0d cnt=%0d", state_a, cnt_a);
    endtask

    task automatic test_cond_wait();
        idle_inputs();
        go_to(7'd7);
        mw_n = 3'b100; mw_s = 2'b01; cond_ok = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        n_cmp++;
        if (state_a !== 7'd7 || cnt_a !== 8'd0 || to_a !== 1'b0 ||
            state_b !== 7'd7 || to_b !== 1'b0) begin
            n_err++;
            $display("FAIL cond_wait: a=%0d/%0d/%0b b=%0d/%0b, required 7/0/0 7/0",
                     state_a, cnt_a, to_a, state_b, to_b);
        end
        $display("txn cond_wait: state=%0d", state_a);
    endtask

    task automatic test_timeout();
        idle_inputs();
        go_to(7'd3);
        mw_n = 3'b100; mw_s = 2'b00; moc = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_cmp++;
            if (state_b !== 7'd3 || cnt_b !== 8'(i) || to_b !== 1'b0) begin
                n_err++;
                $display("FAIL to_hold %0d: state=%0d cnt=%0d to=%0b, required 3/%0d/0", i, state_b, cnt_b, to_b, i);
            end
        end
        tick();
        n_cmp++;
        if (state_b !== 7'd127 || to_b !== 1'b1 || cnt_b !== 8'd0) begin
            n_err++;
            $display("FAIL timeout_fire: state=%0d to=%0b cnt=%0d, required 127/1/0", state_b, to_b, cnt_b);
        end
        mw_n = 3'b101;
        tick();
        n_cmp++;
        if (to_b !== 1'b0 || state_b !== 7'd0) begin
            n_err++;
            $display("FAIL timeout_pulse_end: to=%0b state=%0d, required 0/0", to_b, state_b);
        end
        $display("txn timeout: state=%0d", state_b);

        // Completion on the limit edge wins over the timeout.
        go_to(7'd3);
        mw_n = 3'b100; mw_s = 2'b00; moc = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        moc = 1'b1;
        tick();
        n_cmp++;
        if (state_b !== 7'd4 || to_b !== 1'b0 || cnt_b !== 8'd0) begin
            n_err++;
            $display("FAIL limit_success: state=%0d to=%0b cnt=%0d, required 4/0/0", state_b, to_b, cnt_b);
        end
        $display("txn limit_success: state=%0d", state_b);
    endtask

    task automatic test_random();
        int ea, ca, ta, eb, cb, tb;
        int na, nca, nta, nb, ncb, ntb;
        idle_inputs();
        reset = 1'b1;
        tick();
        ea = 0; ca = 0; ta = 0; eb = 0; cb = 0; tb = 0;
        for (int k = 0; k < 200; k++) begin
            reset    = ($urandom_range(0, 49) == 0);
            // Bias toward MOC waits so the short watchdog fires regularly.
            if ($urandom_range(0, 2) == 0) begin
                mw_n = 3'b100; mw_s = 2'b00; mw_inv = 1'b0;
            end else begin
                mw_n = 3'($urandom_range(0, 7));
                mw_s = 2'($urandom_range(0, 3));
                mw_inv = 1'($urandom_range(0, 1));
            end
            mw_cr    = 7'($urandom_range(0, 127));
            enc_addr = 7'($urandom_range(0, 127));
            moc      = ($urandom_range(0, 5) == 0);
            cond_ok  = 1'($urandom_range(0, 1));
            ir_flag  = 1'($urandom_range(0, 1));
            ref_step(ea, ca, 16, na, nca, nta);
            ref_step(eb, cb, 4, nb, ncb, ntb);
            tick();
            ea = na; ca = nca; ta = nta; eb = nb; cb = ncb; tb = ntb;
            n_cmp++;
            if (int'(state_a) != ea || int'(cnt_a) != ca || int'(to_a) != ta) begin
                n_err++;
                $display("FAIL rand_a %0d: state=%0d cnt=%0d to=%0b, required %0d/%0d/%0d",
                         k, state_a, cnt_a, to_a, ea, ca, ta);
            end
            n_cmp++;
            if (int'(state_b) != eb || int'(cnt_b) != cb || int'(to_b) != tb) begin
                n_err++;
                $display("FAIL rand_b %0d: state=%0d cnt=%0d to=%0b, required %0d/%0d/%0d",
                         k, state_b, cnt_b, to_b, eb, cb, tb);
            end
            $display("txn rand %0d: rst=%0b n=%0d s=%0d inv=%0b a=%0d/%0d b=%0d/%0d/%0b",
                     k, reset, mw_n, mw_s, mw_inv, state_a, cnt_a, state_b, cnt_b, to_b);
        end
        reset = 1'b0;
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_reset_mid_wait();
        test_inc_wrap();
        test_dispatch();
        test_cjump();
        test_moc_wait();
        test_cond_wait();
        test_timeout();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
